// File: rtl/ctrl_seq_unit_pkg.sv
// ctrl_pkg: opcode constants, PCSEL/WDSEL encodings and sequencer state type.
package ctrl_pkg;
    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_ST  = 6'b011001;
    localparam logic [5:0] OP_JMP = 6'b011011;
    localparam logic [5:0] OP_BEQ = 6'b011101;
    localparam logic [5:0] OP_BNE = 6'b011110;
    localparam logic [5:0] OP_LDR = 6'b011111;
    localparam logic [3:0] NIB_MUL = 4'b0010;
    localparam logic [3:0] NIB_DIV = 4'b0011;
    localparam logic [2:0] PC_NEXT  = 3'd0;
    localparam logic [2:0] PC_BR    = 3'd1;
    localparam logic [2:0] PC_JMP   = 3'd2;
    localparam logic [2:0] PC_ILLOP = 3'd3;
    localparam logic [2:0] PC_XADR  = 3'd4;
    localparam logic [1:0] WD_PC  = 2'd0;
    localparam logic [1:0] WD_ALU = 2'd1;
    localparam logic [1:0] WD_MEM = 2'd2;
    typedef enum logic [1:0] {EXEC, MEM_WAIT, MD_WAIT} state_t;
endpackage

// File: rtl/ctrl_seq_unit_if.sv
// ctrl_seq_unit_if: instruction/handshake inputs and datapath control outputs.
//   master: instruction register / datapath side; slave: the control sequencer.
interface ctrl_seq_unit_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUFN_W  = 6,
    parameter int PCSEL_W  = 3
);
    logic [OPCODE_W-1:0] opcode;
    logic                instr_valid, z, irq, mem_ready, md_done;
    logic [PCSEL_W-1:0]  pcsel;
    logic                ra2sel, asel, bsel;
    logic [1:0]          wdsel;
    logic [ALUFN_W-1:0]  alufn;
    logic                wr, werf, wasel, md_start, stall;
    modport master (
        output opcode, instr_valid, z, irq, mem_ready, md_done,
        input  pcsel, ra2sel, asel, bsel, wdsel, alufn, wr, werf, wasel, md_start, stall
    );
    modport slave (
        input  opcode, instr_valid, z, irq, mem_ready, md_done,
        output pcsel, ra2sel, asel, bsel, wdsel, alufn, wr, werf, wasel, md_start, stall
    );
endinterface

// File: rtl/ctrl_decode_rom.sv
// ctrl_decode_rom: combinational opcode decode into datapath fields plus a legal bit.
//   in: opcode_i; out: legal/class flags, mux selects, decoded wr/werf, alufn.
module ctrl_decode_rom
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUFN_W  = 6
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic                legal_o,
    output logic                is_mem_o,
    output logic                is_md_o,
    output logic                is_beq_o,
    output logic                is_bne_o,
    output logic                is_jmp_o,
    output logic                ra2sel_o,
    output logic                asel_o,
    output logic                bsel_o,
    output logic                wr_o,
    output logic                werf_o,
    output logic [1:0]          wdsel_o,
    output logic [ALUFN_W-1:0]  alufn_o
);
    logic [1:0] cls;
    logic [3:0] nib;
    logic       alu_op, ld, st, ldr;
    always_comb begin
        cls = opcode_i[OPCODE_W-1 -: 2];
        nib = opcode_i[3:0];
        // low nibbles 7, 11 and 15 are holes in both ALU groups
        alu_op = cls[1] && !(nib[1:0] == 2'b11 && nib[3:2] != 2'b00);
        ld = opcode_i == OPCODE_W'(OP_LD);
        st = opcode_i == OPCODE_W'(OP_ST);
        ldr = opcode_i == OPCODE_W'(OP_LDR);
        is_jmp_o = opcode_i == OPCODE_W'(OP_JMP);
        is_beq_o = opcode_i == OPCODE_W'(OP_BEQ);
        is_bne_o = opcode_i == OPCODE_W'(OP_BNE);
        legal_o = alu_op || ld || st || ldr || is_jmp_o || is_beq_o || is_bne_o;
        is_mem_o = ld || st || ldr;
        is_md_o = alu_op && (nib == NIB_MUL || nib == NIB_DIV);
        ra2sel_o = st;
        asel_o = ldr;
        bsel_o = (alu_op && cls[0]) || ld || st || ldr;
        wdsel_o = alu_op ? WD_ALU : (ld || ldr) ? WD_MEM : WD_PC;
        wr_o = st;
        werf_o = legal_o && !st;
        alufn_o = legal_o ? opcode_i[ALUFN_W-1:0] : '0;
    end
endmodule

// File: rtl/ctrl_seq_unit.sv
// ctrl_seq_unit: stateful control sequencer with memory/MUL-DIV stalls, traps and IRQ entry.
//   clk, rst: clock and synchronous active-high reset; bus: slave side of ctrl_seq_unit_if.
module ctrl_seq_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W  = 6,
    parameter int ALUFN_W   = 6,
    parameter int PCSEL_W   = 3,
    parameter bit MULDIV_MC = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    ctrl_seq_unit_if.slave bus
);
    logic               d_legal, d_mem, d_md, d_beq, d_bne, d_jmp;
    logic               d_ra2sel, d_asel, d_bsel, d_wr, d_werf;
    logic [1:0]         d_wdsel;
    logic [ALUFN_W-1:0] d_alufn;
    state_t             state_q, state_d;
    logic               irq_q, irq_d, done;

    ctrl_decode_rom #(.OPCODE_W(OPCODE_W), .ALUFN_W(ALUFN_W)) u_rom (
        .opcode_i(bus.opcode), .legal_o(d_legal), .is_mem_o(d_mem), .is_md_o(d_md),
        .is_beq_o(d_beq), .is_bne_o(d_bne), .is_jmp_o(d_jmp), .ra2sel_o(d_ra2sel),
        .asel_o(d_asel), .bsel_o(d_bsel), .wr_o(d_wr), .werf_o(d_werf),
        .wdsel_o(d_wdsel), .alufn_o(d_alufn)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EXEC;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        irq_d = irq_q || bus.irq;
        done = (state_q == MEM_WAIT) ? bus.mem_ready : bus.md_done;
        bus.pcsel = d_jmp ? PCSEL_W'(PC_JMP) :
                    ((d_beq && bus.z) || (d_bne && !bus.z)) ? PCSEL_W'(PC_BR) : PCSEL_W'(PC_NEXT);
        bus.ra2sel = d_ra2sel;
        bus.asel = d_asel;
        bus.bsel = d_bsel;
        bus.wdsel = d_wdsel;
        bus.alufn = d_alufn;
        bus.wr = 1'b0;
        bus.werf = 1'b0;
        bus.wasel = 1'b0;
        bus.md_start = 1'b0;
        bus.stall = 1'b0;
        if (state_q != EXEC) begin
            // selects stay on the held instruction; the write fires only in the done cycle
            bus.stall = !done;
            bus.wr = done && d_wr;
            bus.werf = done && d_werf;
            state_d = done ? EXEC : state_q;
        end else if (bus.instr_valid && irq_q) begin
            bus.pcsel = PCSEL_W'(PC_XADR);
            bus.wasel = 1'b1;
            bus.wdsel = WD_PC;
            bus.werf = 1'b1;
            bus.ra2sel = 1'b0;
            bus.asel = 1'b0;
            bus.bsel = 1'b0;
            bus.alufn = '0;
            // a request arriving in the service cycle stays pending
            irq_d = bus.irq;
        end else if (bus.instr_valid && !d_legal) begin
            bus.pcsel = PCSEL_W'(PC_ILLOP);
            bus.wasel = 1'b1;
            bus.wdsel = WD_PC;
            bus.werf = 1'b1;
        end else if (bus.instr_valid && d_mem && !bus.mem_ready) begin
            bus.stall = 1'b1;
            state_d = MEM_WAIT;
        end else if (bus.instr_valid && d_md && MULDIV_MC) begin
            bus.md_start = 1'b1;
            bus.stall = 1'b1;
            state_d = MD_WAIT;
        end else if (bus.instr_valid) begin
            bus.wr = d_wr;
            bus.werf = d_werf;
        end
        if (rst) begin
            bus.pcsel = '0;
            bus.ra2sel = 1'b0;
            bus.asel = 1'b0;
            bus.bsel = 1'b0;
            bus.wdsel = '0;
            bus.alufn = '0;
            bus.wr = 1'b0;
            bus.werf = 1'b0;
            bus.wasel = 1'b0;
            bus.md_start = 1'b0;
            bus.stall = 1'b0;
        end
    end
endmodule

// File: tb/tb_ctrl_seq_unit.sv
// tb_ctrl_seq_unit: directed checks of decode, stalls, traps, IRQ entry and reset.
module tb_ctrl_seq_unit;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;

    ctrl_seq_unit_if b1 ();
    ctrl_seq_unit_if b0 ();
    ctrl_seq_unit #(.MULDIV_MC(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    ctrl_seq_unit #(.MULDIV_MC(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    always #5 clk = ~clk;

    // {pcsel, wasel, wdsel, werf, wr, stall, md_start}
    function automatic logic [9:0] o1();
        return {b1.pcsel, b1.wasel, b1.wdsel, b1.werf, b1.wr, b1.stall, b1.md_start};
    endfunction
    function automatic logic [9:0] o0();
        return {b0.pcsel, b0.wasel, b0.wdsel, b0.werf, b0.wr, b0.stall, b0.md_start};
    endfunction
    function automatic logic [9:0] ex(input logic [2:0] pc, input logic wa, input logic [1:0] wd,
                                      input logic werf, input logic wr, input logic st, input logic ms);
        return {pc, wa, wd, werf, wr, st, ms};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic v, input logic z, input logic mr, input logic md);
        b1.opcode = op; b1.instr_valid = v; b1.z = z; b1.mem_ready = mr; b1.md_done = md;
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (b1.wr && b1.werf) begin errors++; $display("FAIL wr_werf_together got wr=%b werf=%b", b1.wr, b1.werf); end
        end
    end

    task automatic test_reset();
        logic [9:0] e;
        rst = 1'b1;
        drive(6'b100000, 1'b1, 1'b0, 1'b1, 1'b0);
        e = ex(3'd0, 0, 2'd0, 0, 0, 0, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL reset_outs got %b exp %b", o1(), e); end
        checks++; if (b1.alufn !== 6'd0) begin errors++; $display("FAIL reset_alufn got %h exp 00", b1.alufn); end
        tick();
        rst = 1'b0;
        drive(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        logic [9:0] e;
        drive(6'b100000, 1'b1, 1'b0, 1'b0, 1'b0);
        e = ex(3'd0, 0, 2'd1, 1, 0, 0, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL add got %b exp %b", o1(), e); end
        checks++; if ({b1.alufn, b1.bsel} !== {6'b100000, 1'b0}) begin errors++; $display("FAIL add_alufn got %h/%b exp 20/0", b1.alufn, b1.bsel); end
        drive(6'b110000, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if ({b1.werf, b1.bsel, b1.wdsel} !== 4'b1101) begin errors++; $display("FAIL addc got %b exp 1101", {b1.werf, b1.bsel, b1.wdsel}); end
        drive(6'b011101, 1'b1, 1'b1, 1'b0, 1'b0);
        e = ex(3'd1, 0, 2'd0, 1, 0, 0, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL beq_taken got %b exp %b", o1(), e); end
        drive(6'b011101, 1'b1, 1'b0, 1'b0, 1'b0);
        e = ex(3'd0, 0, 2'd0, 1, 0, 0, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL beq_not got %b exp %b", o1(), e); end
        drive(6'b011110, 1'b1, 1'b0, 1'b0, 1'b0);
        e = ex(3'd1, 0, 2'd0, 1, 0, 0, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL bne_taken got %b exp %b", o1(), e); end
        drive(6'b011011, 1'b1, 1'b0, 1'b0, 1'b0);
        e = ex(3'd2, 0, 2'd0, 1, 0, 0, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL jmp got %b exp %b", o1(), e); end
        drive(6'b100000, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if ({b1.werf, b1.wr, b1.stall, b1.md_start} !== 4'b0000) begin errors++; $display("FAIL invalid got %b exp 0000", {b1.werf, b1.wr, b1.stall, b1.md_start}); end
        tick();
    endtask

    task automatic test_mem();
        logic [9:0] e;
        drive(6'b011000, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            e = ex(3'd0, 0, 2'd2, 0, 0, 1, 0);
            checks++; if (o1() !== e) begin errors++; $display("FAIL ld_wait%0d got %b exp %b", c, o1(), e); end
            tick();
        end
        drive(6'b011000, 1'b1, 1'b0, 1'b1, 1'b0);
        e = ex(3'd0, 0, 2'd2, 1, 0, 0, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL ld_done got %b exp %b", o1(), e); end
        tick();
        drive(6'b011001, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            e = ex(3'd0, 0, 2'd0, 0, 0, 1, 0);
            checks++; if (o1() !== e) begin errors++; $display("FAIL st_wait%0d got %b exp %b", c, o1(), e); end
            tick();
        end
        drive(6'b011001, 1'b1, 1'b0, 1'b1, 1'b0);
        e = ex(3'd0, 0, 2'd0, 0, 1, 0, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL st_done got %b exp %b", o1(), e); end
        checks++; if ({b1.ra2sel, b1.bsel} !== 2'b11) begin errors++; $display("FAIL st_sel got %b exp 11", {b1.ra2sel, b1.bsel}); end
        tick();
        drive(6'b011111, 1'b1, 1'b0, 1'b1, 1'b0);
        e = ex(3'd0, 0, 2'd2, 1, 0, 0, 0);
        checks++; if (o1() !== e || b1.asel !== 1'b1) begin errors++; $display("FAIL ldr_early got %b/%b exp %b/1", o1(), b1.asel, e); end
        tick();
        drive(6'b011000, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL ldr_no_wait got %b exp 0", b1.stall); end
    endtask

    task automatic test_mulc();
        logic [9:0] e;
        b0.opcode = 6'b110010; b0.instr_valid = 1'b1;
        drive(6'b110010, 1'b1, 1'b0, 1'b0, 1'b1);
        e = ex(3'd0, 0, 2'd1, 0, 0, 1, 1);
        checks++; if (o1() !== e) begin errors++; $display("FAIL mulc_start got %b exp %b", o1(), e); end
        e = ex(3'd0, 0, 2'd1, 1, 0, 0, 0);
        checks++; if (o0() !== e) begin errors++; $display("FAIL mulc_single got %b exp %b", o0(), e); end
        tick();
        b0.instr_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            drive(6'b110010, 1'b1, 1'b0, 1'b0, 1'b0);
            e = ex(3'd0, 0, 2'd1, 0, 0, 1, 0);
            checks++; if (o1() !== e) begin errors++; $display("FAIL mulc_wait%0d got %b exp %b", c, o1(), e); end
            tick();
        end
        drive(6'b110010, 1'b1, 1'b0, 1'b0, 1'b1);
        e = ex(3'd0, 0, 2'd1, 1, 0, 0, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL mulc_done got %b exp %b", o1(), e); end
        tick();
        drive(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_illegal();
        logic [9:0] e;
        drive(6'b000101, 1'b1, 1'b0, 1'b0, 1'b0);
        e = ex(3'd3, 1, 2'd0, 1, 0, 0, 0);
        checks++; if (o1() !== e || b1.alufn !== 6'd0) begin errors++; $display("FAIL illop got %b/%h exp %b/00", o1(), b1.alufn, e); end
        drive(6'b100111, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL illop_hole got %b exp %b", o1(), e); end
        tick();
    endtask

    task automatic test_irq_stall();
        logic [9:0] e;
        drive(6'b011000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        b1.irq = 1'b1;
        drive(6'b011000, 1'b1, 1'b0, 1'b0, 1'b0);
        e = ex(3'd0, 0, 2'd2, 0, 0, 1, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL irq_mid_stall got %b exp %b", o1(), e); end
        tick();
        b1.irq = 1'b0;
        drive(6'b011000, 1'b1, 1'b0, 1'b1, 1'b0);
        e = ex(3'd0, 0, 2'd2, 1, 0, 0, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL irq_ld_done got %b exp %b", o1(), e); end
        tick();
        drive(6'b100000, 1'b1, 1'b0, 1'b0, 1'b0);
        e = ex(3'd4, 1, 2'd0, 1, 0, 0, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL irq_entry got %b exp %b", o1(), e); end
        tick();
        drive(6'b100000, 1'b1, 1'b0, 1'b0, 1'b0);
        e = ex(3'd0, 0, 2'd1, 1, 0, 0, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL irq_cleared got %b exp %b", o1(), e); end
        tick();
    endtask

    task automatic test_reset_md();
        logic [9:0] e;
        drive(6'b110011, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        drive(6'b110011, 1'b1, 1'b0, 1'b0, 1'b0);
        e = ex(3'd0, 0, 2'd0, 0, 0, 0, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL rst_md_outs got %b exp %b", o1(), e); end
        tick();
        rst = 1'b0;
        drive(6'b110011, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if ({b1.werf, b1.wr, b1.stall} !== 3'b000) begin errors++; $display("FAIL rst_md_done_ignored got %b exp 000", {b1.werf, b1.wr, b1.stall}); end
        tick();
        drive(6'b100000, 1'b1, 1'b0, 1'b0, 1'b0);
        e = ex(3'd0, 0, 2'd1, 1, 0, 0, 0);
        checks++; if (o1() !== e) begin errors++; $display("FAIL rst_md_exec got %b exp %b", o1(), e); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        b1.irq = 1'b0;
        b0.opcode = '0; b0.instr_valid = 1'b0; b0.z = 1'b0; b0.irq = 1'b0; b0.mem_ready = 1'b0; b0.md_done = 1'b0;
        drive(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        test_reset();
        test_single();
        test_mem();
        test_mulc();
        test_illegal();
        test_irq_stall();
        test_reset_md();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
